// File: rtl/scr1_dbgc_hart_cmd_seq.sv
// Debug-controller hart command sequencer: turns HALT/RESUME/EXEC operations into the
// hart command req/ack/nack handshake and returns one status word per operation.
module scr1_dbgc_hart_cmd_seq #(
  parameter int CMD_TIMEOUT = 256,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic                   req_sstep,
  input  logic [INSTR_WIDTH-1:0] req_instr,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_status,
  output logic                   hart_cmd,
  output logic                   hart_cmd_req,
  input  logic                   hart_cmd_ack,
  input  logic                   hart_cmd_nack,
  input  logic                   hart_halted,
  input  logic                   hart_except,
  output logic                   hart_fetch_dbgc,
  output logic                   hart_sstep_en,
  output logic [INSTR_WIDTH-1:0] hart_instr
);

  localparam int CNT_W = (CMD_TIMEOUT > 2) ? $clog2(CMD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CMD_TIMEOUT - 1);

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RESUME = 2'b01;
  localparam logic [1:0] OP_EXEC   = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_EXC     = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT_RUN,
    WAIT_HALT,
    RSP
  } state_t;

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic                   exec_op, exec_op_nx;
  logic                   abort, abort_nx;
  logic [1:0]             status_nx;
  logic                   rsp_valid_nx;
  logic                   hart_cmd_nx;
  logic                   cmd_req_nx;
  logic                   fetch_nx;
  logic                   sstep_nx;
  logic [INSTR_WIDTH-1:0] instr_nx;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      exec_op         <= 1'b0;
      abort           <= 1'b0;
      rsp_status      <= '0;
      rsp_valid       <= 1'b0;
      hart_cmd        <= 1'b0;
      hart_cmd_req    <= 1'b0;
      hart_fetch_dbgc <= 1'b0;
      hart_sstep_en   <= 1'b0;
      hart_instr      <= '0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      exec_op         <= exec_op_nx;
      abort           <= abort_nx;
      rsp_status      <= status_nx;
      rsp_valid       <= rsp_valid_nx;
      hart_cmd        <= hart_cmd_nx;
      hart_cmd_req    <= cmd_req_nx;
      hart_fetch_dbgc <= fetch_nx;
      hart_sstep_en   <= sstep_nx;
      hart_instr      <= instr_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    exec_op_nx   = exec_op;
    abort_nx     = abort;
    status_nx    = rsp_status;
    rsp_valid_nx = 1'b0;
    hart_cmd_nx  = hart_cmd;
    cmd_req_nx   = hart_cmd_req;
    fetch_nx     = hart_fetch_dbgc;
    sstep_nx     = hart_sstep_en;
    instr_nx     = hart_instr;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          exec_op_nx = 1'b0;
          case (req_op)
            OP_HALT: begin
              hart_cmd_nx = 1'b1;
              cmd_req_nx  = 1'b1;
              cnt_nx      = CNT_INIT;
              state_nx    = CMD;
            end
            OP_RESUME: begin
              hart_cmd_nx = 1'b0;
              sstep_nx    = req_sstep;
              fetch_nx    = 1'b0;
              cmd_req_nx  = 1'b1;
              cnt_nx      = CNT_INIT;
              state_nx    = CMD;
            end
            OP_EXEC: begin
              if (hart_halted) begin
                instr_nx    = req_instr;
                fetch_nx    = 1'b1;
                sstep_nx    = 1'b1;
                hart_cmd_nx = 1'b0;
                exec_op_nx  = 1'b1;
                cmd_req_nx  = 1'b1;
                cnt_nx      = CNT_INIT;
                state_nx    = CMD;
              end else begin
                status_nx    = ST_NACK;
                rsp_valid_nx = 1'b1;
                state_nx     = RSP;
              end
            end
            default: begin
              status_nx    = ST_NACK;
              rsp_valid_nx = 1'b1;
              state_nx     = RSP;
            end
          endcase
        end
      end

      CMD: begin
        if (hart_cmd_ack || hart_cmd_nack || (cnt == '0)) begin
          cmd_req_nx = 1'b0;
          // An aborted EXEC, a forced halt (ack+nack) or silence all end as TIMEOUT
          if (abort || (hart_cmd_ack == hart_cmd_nack)) begin
            status_nx    = ST_TIMEOUT;
            rsp_valid_nx = 1'b1;
            state_nx     = RSP;
          end else if (hart_cmd_nack) begin
            status_nx    = ST_NACK;
            rsp_valid_nx = 1'b1;
            state_nx     = RSP;
          end else if (exec_op) begin
            cnt_nx   = CNT_INIT;
            state_nx = WAIT_RUN;
          end else begin
            status_nx    = ST_OK;
            rsp_valid_nx = 1'b1;
            state_nx     = RSP;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      WAIT_RUN: begin
        if (!hart_halted) begin
          cnt_nx   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
          state_nx = WAIT_HALT;
        end else if (cnt == '0) begin
          abort_nx    = 1'b1;
          hart_cmd_nx = 1'b1;
          cmd_req_nx  = 1'b1;
          cnt_nx      = CNT_INIT;
          state_nx    = CMD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      WAIT_HALT: begin
        // The budget carries over from WAIT_RUN so it bounds the whole re-halt wait
        if (hart_halted) begin
          status_nx    = hart_except ? ST_EXC : ST_OK;
          rsp_valid_nx = 1'b1;
          state_nx     = RSP;
        end else if (cnt == '0) begin
          abort_nx    = 1'b1;
          hart_cmd_nx = 1'b1;
          cmd_req_nx  = 1'b1;
          cnt_nx      = CNT_INIT;
          state_nx    = CMD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end

      RSP: begin
        fetch_nx = 1'b0;
        sstep_nx = 1'b0;
        abort_nx = 1'b0;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_scr1_dbgc_hart_cmd_seq.sv
// Directed self-checking bench for scr1_dbgc_hart_cmd_seq; expected statuses are queued
// at request time and popped by a response monitor.
module tb_scr1_dbgc_hart_cmd_seq;

  localparam int TMO = 4;
  localparam int IW  = 32;

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RESUME = 2'b01;
  localparam logic [1:0] OP_EXEC   = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_EXC     = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic          req_sstep = 1'b0;
  logic [IW-1:0] req_instr = '0;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic          hart_cmd;
  logic          hart_cmd_req;
  logic          hart_cmd_ack = 1'b0;
  logic          hart_cmd_nack = 1'b0;
  logic          hart_halted = 1'b0;
  logic          hart_except = 1'b0;
  logic          hart_fetch_dbgc;
  logic          hart_sstep_en;
  logic [IW-1:0] hart_instr;

  int n_vec = 0;
  int n_err = 0;
  int req_run = 0;
  int last_run = 0;
  logic [1:0] exp_q[$];

  scr1_dbgc_hart_cmd_seq #(.CMD_TIMEOUT(TMO), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_sstep(req_sstep), .req_instr(req_instr),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .hart_cmd(hart_cmd), .hart_cmd_req(hart_cmd_req),
    .hart_cmd_ack(hart_cmd_ack), .hart_cmd_nack(hart_cmd_nack),
    .hart_halted(hart_halted), .hart_except(hart_except),
    .hart_fetch_dbgc(hart_fetch_dbgc), .hart_sstep_en(hart_sstep_en),
    .hart_instr(hart_instr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request through acceptance; returns one cycle after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic sstep,
                               input logic [IW-1:0] instr, input logic [1:0] exp_st);
    int k = 0;
    while (!req_ready && k < 20) begin
      tick();
      k++;
    end
    checkOutput("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_sstep = sstep;
    req_instr = instr;
    exp_q.push_back(exp_st);
    tick();
    req_valid = 1'b0;
    req_op    = '0;
    req_sstep = 1'b0;
    req_instr = '0;
  endtask

  task automatic waitRsp(input string tag, input int max, output int cycles);
    cycles = 0;
    while (!rsp_valid && cycles < max) begin
      tick();
      cycles++;
    end
    checkOutput(tag, rsp_valid, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      checkOutput("rsp_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) checkOutput("rsp_status", rsp_status, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (hart_cmd_req) req_run++;
    else begin
      if (req_run != 0) last_run = req_run;
      req_run = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    #12;
    checkOutput("reset_outputs",
                {hart_cmd, hart_cmd_req, hart_fetch_dbgc, hart_sstep_en, rsp_valid, rsp_status},
                7'b0);
    checkOutput("reset_instr", hart_instr, 0);
    checkOutput("reset_ready", req_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // HALT, ack in third request cycle
    applyStimulus(OP_HALT, 1'b0, '0, ST_OK);
    checkOutput("halt_cmd", hart_cmd, 1);
    checkOutput("halt_req_c1", hart_cmd_req, 1);
    checkOutput("halt_not_ready", req_ready, 0);
    tick();
    checkOutput("halt_req_c2", hart_cmd_req, 1);
    tick();
    checkOutput("halt_req_c3", hart_cmd_req, 1);
    hart_cmd_ack = 1'b1;
    tick();
    hart_cmd_ack = 1'b0;
    hart_halted  = 1'b1;
    checkOutput("halt_req_dropped", hart_cmd_req, 0);
    checkOutput("halt_rsp_valid", rsp_valid, 1);
    tick();
    checkOutput("halt_req_len", last_run, 3);
    checkOutput("halt_rsp_one_cycle", rsp_valid, 0);
    checkOutput("halt_ready_again", req_ready, 1);

    // RESUME with single-step, nack on first cycle
    applyStimulus(OP_RESUME, 1'b1, '0, ST_NACK);
    checkOutput("resume_sstep_cmd", hart_sstep_en, 1);
    checkOutput("resume_cmd", hart_cmd, 0);
    checkOutput("resume_req", hart_cmd_req, 1);
    hart_cmd_nack = 1'b1;
    tick();
    hart_cmd_nack = 1'b0;
    checkOutput("resume_rsp_valid", rsp_valid, 1);
    checkOutput("resume_req_dropped", hart_cmd_req, 0);
    tick();
    checkOutput("resume_sstep_cleared", hart_sstep_en, 0);

    // EXEC while halted, clean re-halt then re-halt with exception
    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus(OP_EXEC, 1'b0, 32'h0010_0093, (pass == 0) ? ST_OK : ST_EXC);
      checkOutput("exec_fetch_cmd", hart_fetch_dbgc, 1);
      checkOutput("exec_instr", hart_instr, 32'h0010_0093);
      checkOutput("exec_sstep", hart_sstep_en, 1);
      checkOutput("exec_cmd_run", {hart_cmd, hart_cmd_req}, 2'b01);
      hart_cmd_ack = 1'b1;
      tick();
      hart_cmd_ack = 1'b0;
      hart_halted  = 1'b0;
      checkOutput("exec_req_dropped", hart_cmd_req, 0);
      tick();
      checkOutput("exec_fetch_run1", hart_fetch_dbgc, 1);
      tick();
      checkOutput("exec_fetch_run2", hart_fetch_dbgc, 1);
      checkOutput("exec_no_early_rsp", rsp_valid, 0);
      hart_halted = 1'b1;
      hart_except = (pass == 1);
      tick();
      hart_except = 1'b0;
      checkOutput("exec_rsp_valid", rsp_valid, 1);
      checkOutput("exec_fetch_rsp", hart_fetch_dbgc, 1);
      tick();
      checkOutput("exec_fetch_cleared", hart_fetch_dbgc, 0);
      checkOutput("exec_instr_held", hart_instr, 32'h0010_0093);
    end

    // HALT with no handshake: request held exactly TMO cycles
    applyStimulus(OP_HALT, 1'b0, '0, ST_TIMEOUT);
    waitRsp("halt_tmo_rsp", 20, k);
    checkOutput("halt_tmo_latency", k, TMO);
    tick();
    checkOutput("halt_tmo_req_len", last_run, TMO);

    // ack and nack together
    applyStimulus(OP_HALT, 1'b0, '0, ST_TIMEOUT);
    hart_cmd_ack  = 1'b1;
    hart_cmd_nack = 1'b1;
    tick();
    hart_cmd_ack  = 1'b0;
    hart_cmd_nack = 1'b0;
    checkOutput("both_rsp_valid", rsp_valid, 1);
    tick();

    // EXEC where the hart never re-halts: forced halt after the budget
    applyStimulus(OP_EXEC, 1'b0, 32'h0000_0013, ST_TIMEOUT);
    hart_cmd_ack = 1'b1;
    tick();
    hart_cmd_ack = 1'b0;
    hart_halted  = 1'b0;
    k = 0;
    while (!hart_cmd_req && k < 20) begin
      tick();
      k++;
    end
    checkOutput("force_halt_req", hart_cmd_req, 1);
    checkOutput("force_halt_cmd", hart_cmd, 1);
    checkOutput("force_halt_delay", k, TMO);
    checkOutput("force_no_rsp", rsp_valid, 0);
    hart_cmd_ack = 1'b1;
    tick();
    hart_cmd_ack = 1'b0;
    hart_halted  = 1'b1;
    checkOutput("force_rsp_valid", rsp_valid, 1);
    tick();

    // EXEC while running: immediate NACK, no command
    hart_halted = 1'b0;
    applyStimulus(OP_EXEC, 1'b0, 32'hdead_beef, ST_NACK);
    checkOutput("exec_run_rsp", rsp_valid, 1);
    checkOutput("exec_run_req_c1", hart_cmd_req, 0);
    tick();
    checkOutput("exec_run_req_c2", hart_cmd_req, 0);
    checkOutput("exec_run_instr_kept", hart_instr, 32'h0000_0013);
    hart_halted = 1'b1;

    // Reserved op
    applyStimulus(OP_RSVD, 1'b0, '0, ST_NACK);
    checkOutput("rsvd_rsp", rsp_valid, 1);
    checkOutput("rsvd_req", hart_cmd_req, 0);
    tick();

    // Reset pulse during WAIT_HALT aborts silently
    applyStimulus(OP_EXEC, 1'b0, 32'h1234_5678, ST_OK);
    hart_cmd_ack = 1'b1;
    tick();
    hart_cmd_ack = 1'b0;
    hart_halted  = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_abort_outputs",
                {hart_cmd, hart_cmd_req, hart_fetch_dbgc, hart_sstep_en, rsp_valid},
                5'b0);
    checkOutput("rst_abort_instr", hart_instr, 0);
    exp_q.delete();
    hart_halted = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    checkOutput("rst_abort_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_abort_no_rsp", rsp_valid, 0);
      tick();
    end

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scr1_dbgc_hart_cmd_seq.md
# scr1_dbgc_hart_cmd_seq

Debug-controller-side hart command sequencer that sits directly upstream of the hart debug agent. It turns single high-level debug operations (HALT, RESUME, EXEC one instruction) into the hart command request/ack/nack handshake. It also drives the run-control fields (fetch source, single-step, instruction), supervises timeouts and returns one status word per operation.

## Interface
- CMD_TIMEOUT, 256: maximum cycles `hart_cmd_req` is held, and maximum cycles spent waiting for re-halt in EXEC; power of 2, ≥4
- INSTR_WIDTH, 32: debug instruction width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  operation request
- req_ready  out  1  sequencer idle; the request is accepted when both req_valid and req_ready are high
- req_op  in  2  00 HALT, 01 RESUME, 10 EXEC, 11 reserved (answered NACK)
- req_sstep  in  1  RESUME only: enable single-step
- req_instr  in  INSTR_WIDTH  EXEC only: instruction to execute
- rsp_valid  out  1  one-cycle response pulse
- rsp_status  out  2  00 OK, 01 NACK, 10 TIMEOUT, 11 EXC; valid only with rsp_valid
- hart_cmd  out  1  1 = enter debug mode, 0 = run
- hart_cmd_req  out  1  command request level
- hart_cmd_ack  in  1  command accepted
- hart_cmd_nack  in  1  command refused
- hart_halted  in  1  registered hart halted state
- hart_except  in  1  registered "halt entered with exception" flag
- hart_fetch_dbgc  out  1  runctrl fetch source = DBGC
- hart_sstep_en  out  1  runctrl single-step enable
- hart_instr  out  INSTR_WIDTH  instruction presented to hart

## Operation
- States: IDLE, CMD, WAIT_RUN, WAIT_HALT, RSP. `req_ready` = (state == IDLE). All other outputs are registered.
- Reset: state IDLE. All outputs 0, `hart_instr` 0, timeout counter 0. Asserting reset in any state aborts the operation and produces no response.
- IDLE, HALT accepted: `hart_cmd` = 1, go to CMD.
- IDLE, RESUME accepted: `hart_cmd` = 0, `hart_sstep_en` = `req_sstep`, `hart_fetch_dbgc` = 0, go to CMD.
- IDLE, EXEC accepted:
  - If `hart_halted` = 1: latch `req_instr` into `hart_instr`, set `hart_fetch_dbgc` = 1, `hart_sstep_en` = 1, `hart_cmd` = 0, go to CMD.
  - If `hart_halted` = 0: go straight to RSP with NACK. No hart command is issued.
- IDLE, reserved op accepted: go to RSP with NACK.
- CMD:
  - `hart_cmd_req` = 1. The timeout counter is loaded with CMD_TIMEOUT-1 on entry and decrements each cycle in which neither ack nor nack is seen.
  - ack only: drop the request. HALT/RESUME go to RSP with OK. EXEC goes to WAIT_RUN.
  - nack only: drop the request, go to RSP with NACK.
  - ack and nack in the same cycle (forced halt on hart timeout): go to RSP with TIMEOUT.
  - Counter = 0 with neither ack nor nack: drop the request, go to RSP with TIMEOUT.
  - Abort halt (`abort` flag set, see WAIT_HALT): ack gives TIMEOUT; nack gives TIMEOUT.
- WAIT_RUN: wait for `hart_halted` = 0, then go to WAIT_HALT. The counter reloads on entry and decrements each cycle.
- WAIT_HALT: on `hart_halted` = 1, go to RSP with EXC if `hart_except`, else OK.
- Timeout in WAIT_RUN or WAIT_HALT: set `abort`, set `hart_cmd` = 1, go to CMD. This issues a forced HALT.
- RSP: `rsp_valid` = 1 for one cycle, then IDLE. `hart_fetch_dbgc`, `hart_sstep_en` and `abort` clear on leaving RSP. `hart_instr` holds its last value.
- `req_*` inputs are sampled only at acceptance.

## Timing
- Accept in cycle N → `hart_cmd_req` high from N+1.
- Ack or nack sampled in cycle M → `hart_cmd_req` low at M+1, and `rsp_valid` at M+1 (HALT/RESUME). The next request can be accepted at M+2.
- `hart_cmd_req` is never high for more than CMD_TIMEOUT consecutive cycles and never deasserts without a terminating event.
- EXEC: `rsp_valid` arrives one cycle after `hart_halted` is seen high in WAIT_HALT.
- NACK for EXEC-while-running or a reserved op: `rsp_valid` at N+1.
- Exactly one `rsp_valid` pulse per accepted request.

## Test plan
- HALT with ack on the 3rd request cycle → `hart_cmd` = 1, `hart_cmd_req` high for 3 cycles, `rsp_valid` with 00 the next cycle.
- RESUME with `req_sstep` = 1 and nack on the 1st cycle → `hart_sstep_en` = 1 during CMD, `rsp_status` 01, `hart_sstep_en` back to 0 after RSP.
- EXEC with instr 0x00100093 while halted; ack; `hart_halted` goes 1→0 for 2 cycles then 1 with `hart_except` = 0 → `hart_fetch_dbgc` = 1 throughout, `hart_instr` = 0x00100093, status 00. Repeat with `hart_except` = 1 → status 11.
- HALT, CMD_TIMEOUT = 4, no ack or nack → `hart_cmd_req` high exactly 4 cycles, status 10. Ack and nack together → status 10.
- EXEC with hart never re-halting → after CMD_TIMEOUT cycles a forced HALT is issued (`hart_cmd` = 1); on ack, status 10. EXEC while `hart_halted` = 0 → status 01 at N+1 and `hart_cmd_req` never asserts.
- `rst_n` pulsed during WAIT_HALT → all outputs 0 asynchronously, no `rsp_valid`, `req_ready` = 1 after release.
